// File: rtl/top_module_logical_tx1.sv
// Single-lane 128b/130b logical-layer transmitter.
// Frames BLOCK_BYTES payload bytes behind a 2-bit sync header. The payload is
// optionally scrambled with the Gen3 LFSR and sent LSB-first on one bit line.
module top_module_logical_tx1 #(
  parameter logic [22:0] SEED        = 23'h1DBFBC,
  parameter int          BLOCK_BYTES = 16
) (
  input  logic       clk8,
  input  logic       rst8,
  input  logic       k,
  input  logic       tx_valid,
  input  logic       tx_start,
  input  logic [7:0] DLL_data,
  input  logic [1:0] en_scram,
  output logic       data_out,
  output logic       data_req,
  output logic       busy
);

  localparam int         BLK_BITS   = 2 + 8 * BLOCK_BYTES;
  localparam logic [7:0] LAST_CNT   = 8'(BLK_BITS - 1);
  localparam logic [7:0] LAST_FETCH = 8'(BLK_BITS - 9);

  // Fibonacci LFSR, x^23+x^21+x^16+x^8+x^5+x^2+1
  function automatic logic [22:0] lfsr_step(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  logic [7:0]  cnt_q,  cnt_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;
  logic        type_q, type_d;
  logic [22:0] lfsr_q, lfsr_d;
  logic [6:0]  sh_q,   sh_d;

  logic start_ok;
  logic fetch;
  logic scr_en;
  logic key;

  // Block-start qualification, byte-fetch strobe and scrambler key bit
  always_comb begin
    start_ok = tx_valid & tx_start & (~busy_q | (cnt_q == LAST_CNT));
    fetch    = busy_q & (cnt_q[2:0] == 3'd1) & (cnt_q <= LAST_FETCH);
    scr_en   = type_q ? en_scram[1] : en_scram[0];
    key      = scr_en & lfsr_q[22];
  end

  // Next-state: abort, start, header, payload serialization, block end
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dout_d = dout_q;
    type_d = type_q;
    lfsr_d = lfsr_q;
    sh_d   = sh_q;
    if (!tx_valid) begin
      // Abort: drop the partial block and restart scrambling from the seed
      busy_d = 1'b0;
      cnt_d  = 8'd0;
      dout_d = 1'b0;
      lfsr_d = SEED;
    end else if (start_ok) begin
      // H0 equals k: data block sends 0,1; ordered set sends 1,0
      type_d = k;
      busy_d = 1'b1;
      cnt_d  = 8'd0;
      dout_d = k;
    end else if (busy_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'd0) begin
        dout_d = ~type_q;
      end else if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        cnt_d  = 8'd0;
        dout_d = 1'b0;
      end else begin
        // Payload bit: the LFSR advances whether or not scrambling is enabled
        lfsr_d = lfsr_step(lfsr_q);
        if (fetch) begin
          dout_d = DLL_data[0] ^ key;
          sh_d   = DLL_data[7:1];
        end else begin
          dout_d = sh_q[0] ^ key;
          sh_d   = {1'b0, sh_q[6:1]};
        end
      end
    end else begin
      dout_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk8) begin
    if (rst8) begin
      cnt_q  <= 8'd0;
      busy_q <= 1'b0;
      dout_q <= 1'b0;
      type_q <= 1'b0;
      lfsr_q <= SEED;
      sh_q   <= 7'd0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dout_q <= dout_d;
      type_q <= type_d;
      lfsr_q <= lfsr_d;
      sh_q   <= sh_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign data_req = fetch & tx_valid;

endmodule

// File: tb/tb_top_module_logical_tx1.sv
// Directed bench for the 128b/130b logical transmitter.
module tb_top_module_logical_tx1;

  localparam logic [22:0] SEED = 23'h1DBFBC;

  logic       clk8 = 1'b0;
  logic       rst8;
  logic       k;
  logic       tx_valid;
  logic       tx_start;
  logic [7:0] DLL_data;
  logic [1:0] en_scram;
  logic       data_out;
  logic       data_req;
  logic       busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [22:0] lfsr_m;
  logic [7:0]  pay [16];
  logic [7:0]  first_byte;

  top_module_logical_tx1 #(.SEED(SEED), .BLOCK_BYTES(16)) dut (
    .clk8     (clk8),
    .rst8     (rst8),
    .k        (k),
    .tx_valid (tx_valid),
    .tx_start (tx_start),
    .DLL_data (DLL_data),
    .en_scram (en_scram),
    .data_out (data_out),
    .data_req (data_req),
    .busy     (busy)
  );

  always #5 clk8 = ~clk8;

  function automatic logic [22:0] ref_step(input logic [22:0] s);
    logic fb;
    fb = s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1];
    return {s[21:0], fb};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int n = 0; n < 16; n++) pay[n] = v;
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 16; n++) pay[n] = 8'($urandom);
  endtask

  // Drop tx_valid for one edge (also tries a start that must be refused)
  task automatic reseed();
    tx_valid = 1'b0;
    tx_start = 1'b1;
    @(negedge clk8);
    check_eq("nostart_busy", busy, 1'b0);
    check_eq("nostart_dout", data_out, 1'b0);
    check_eq("nostart_req", data_req, 1'b0);
    tx_start = 1'b0;
    tx_valid = 1'b1;
    lfsr_m   = SEED;
    @(negedge clk8);
  endtask

  task automatic start_pulse(input logic kk);
    k        = kk;
    tx_start = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk8);
  endtask

  // Entered at the negedge where cnt==0 of a block of type kk
  task automatic run_block(input logic kk, input logic chain, input logic chain_k,
                           input int abort_at, input int ign_at);
    logic scr;
    logic expb;
    logic exp_req;
    int   i;
    int   b;
    int   req_cnt;
    logic aborted;
    tx_start = 1'b0;
    scr      = kk ? en_scram[1] : en_scram[0];
    req_cnt  = 0;
    aborted  = 1'b0;
    check_eq("hdr0", data_out, kk);
    check_eq("busy_c0", busy, 1'b1);
    check_eq("req_c0", data_req, 1'b0);
    @(negedge clk8);
    for (int c = 1; c <= 129; c++) begin
      if (ign_at > 0 && c == ign_at + 1) begin
        tx_start = 1'b0;
        k        = kk;
      end
      if (c == 1) begin
        expb = ~kk;
      end else begin
        i    = (c - 2) / 8;
        b    = (c - 2) % 8;
        expb = pay[i][b] ^ (scr & lfsr_m[22]);
        lfsr_m = ref_step(lfsr_m);
        if (c - 2 < 8) first_byte[c-2] = data_out;
      end
      exp_req = ((c % 8) == 1) && (c <= 121);
      check_eq("bit", data_out, expb);
      check_eq("busy", busy, 1'b1);
      check_eq("req", data_req, exp_req);
      if (data_req) req_cnt++;
      if (exp_req) DLL_data = pay[(c-1)/8];
      else         DLL_data = 8'($urandom);
      if (c == abort_at) begin
        tx_valid = 1'b0;
        check_eq("abort_req_comb", data_req, 1'b0);
        @(negedge clk8);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_dout", data_out, 1'b0);
        check_eq("abort_req", data_req, 1'b0);
        tx_valid = 1'b1;
        lfsr_m   = SEED;
        aborted  = 1'b1;
        break;
      end
      if (ign_at > 0 && c == ign_at) begin
        tx_start = 1'b1;
        k        = ~kk;
      end
      if (c == 129 && chain) begin
        tx_start = 1'b1;
        k        = chain_k;
      end
      @(negedge clk8);
    end
    if (!aborted) begin
      check_eq("nreq", req_cnt, 16);
      if (!chain) begin
        check_eq("end_busy", busy, 1'b0);
        check_eq("end_dout", data_out, 1'b0);
        check_eq("end_req", data_req, 1'b0);
      end
    end
  endtask

  initial begin
    rst8     = 1'b1;
    k        = 1'b0;
    tx_valid = 1'b1;
    tx_start = 1'b1;
    DLL_data = 8'h00;
    en_scram = 2'b00;

    // Reset dominates a pending start
    repeat (3) begin
      @(negedge clk8);
      check_eq("rst_dout", data_out, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_req", data_req, 1'b0);
    end
    rst8     = 1'b0;
    tx_start = 1'b0;
    lfsr_m   = SEED;
    @(negedge clk8);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_dout", data_out, 1'b0);

    // Ordered-set block, unscrambled A5 bytes
    en_scram = 2'b00;
    fill_const(8'hA5);
    start_pulse(1'b1);
    run_block(1'b1, 1'b0, 1'b0, 0, 0);

    // Data block, scrambled zeros: payload is the raw LFSR stream from SEED
    reseed();
    en_scram = 2'b01;
    fill_const(8'h00);
    start_pulse(1'b0);
    run_block(1'b0, 1'b0, 1'b0, 0, 0);
    check_eq("lfsr_first8", first_byte, 8'hDC);

    // 68 back-to-back scrambled data blocks
    reseed();
    en_scram = 2'b11;
    start_pulse(1'b0);
    for (int j = 0; j < 68; j++) begin
      fill_rand();
      run_block(1'b0, (j < 67), 1'b0, 0, 0);
    end

    // Abort at cnt=50, then restart from the seed
    reseed();
    en_scram = 2'b11;
    fill_rand();
    start_pulse(1'b0);
    run_block(1'b0, 1'b0, 1'b0, 50, 0);
    fill_rand();
    start_pulse(1'b0);
    run_block(1'b0, 1'b0, 1'b0, 0, 0);

    // Stray start at cnt=60 is ignored (scrambled ordered set)
    reseed();
    en_scram = 2'b10;
    fill_rand();
    start_pulse(1'b1);
    run_block(1'b1, 1'b0, 1'b0, 0, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top_module_logical_tx1.md
Name: top_module_logical_tx1

Overview:
- Single-lane 128b/130b logical-layer transmitter: frames 16 payload bytes from the data-link layer into a 130-bit block.
- Each block carries a 2-bit sync header; payload is optionally scrambled with the Gen3 LFSR and serialized LSB-first onto one bit line.
- Sits between the DLL byte source and the PHY electrical serial driver, running entirely in the bit-clock domain.

Parameters:
- SEED, 23'h1DBFBC, LFSR reseed value.
- BLOCK_BYTES, 16, payload bytes per block. Fixed; block length is 2+8*BLOCK_BYTES = 130.

Ports:
- clk8  input  1  bit clock, rising edge.
- rst8  input  1  synchronous active-high reset.
- k  input  1  block type, sampled with tx_start: 1 = ordered-set block, 0 = data block. Don't-care otherwise.
- tx_valid  input  1  transmit enable level. Low forces idle.
- tx_start  input  1  one-cycle pulse requesting a new block.
- DLL_data  input  8  payload byte, sampled only when data_req=1.
- en_scram  input  2  [0] scramble data-block payload; [1] scramble ordered-set payload.
- data_out  output  1  serial bit, registered.
- data_req  output  1  high during the cycle in which DLL_data is consumed.
- busy  output  1  block in progress.

Behaviour:
- Reset (rst8=1 at an edge) sets:
  - data_out=0, data_req=0, busy=0, bit counter cnt=0.
  - LFSR=SEED; type register=0.
  - Reset dominates all inputs.
- Idle (busy=0): data_out=0, data_req=0.
- Block start: at an edge with tx_valid=1 and tx_start=1, while idle or while cnt==129, the block starts:
  - Latch k; busy←1; cnt←0.
  - data_out←H0.
- tx_start at any other cnt is ignored.
- Sync header (never scrambled):
  - Data block (k=0): H0=0, H1=1.
  - Ordered-set block (k=1): H0=1, H1=0.
- Counter: cnt increments by 1 per edge while busy.
  - cnt=1 → data_out=H1.
  - cnt=c for c in 2..129 → payload byte i=(c-2)/8, bit (c-2)%8, LSB first.
- Byte fetch:
  - data_req=1 combinationally when busy and cnt ∈ {1,9,17,...,121}, i.e. cnt=8i+1, 16 strobes per block.
  - At the edge ending that cycle, DLL_data is captured: data_out←DLL_data[0]^m, and DLL_data[7:1] goes to the shift register.
  - The following 7 edges shift out bits 1..7.
- Scrambler: Fibonacci LFSR s[22:0], polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
  - Key bit m = s[22] if scrambling is enabled for the latched block type (data: en_scram[0]; OS: en_scram[1]), else 0.
  - On every payload bit, enabled or not: s←{s[21:0], s[22]^s[20]^s[15]^s[7]^s[4]^s[1]}.
  - The LFSR holds during header bits.
  - The LFSR is reseeded to SEED on reset and whenever tx_valid=0.
  - The LFSR continues across back-to-back blocks.
- Block end:
  - After the edge where cnt==129 with no new start: busy←0 and data_out←0 on the next edge.
  - A start accepted at cnt==129 gives a seamless next block (H0 immediately follows payload bit 127).
- Abort: tx_valid=0 at any edge:
  - busy←0, cnt←0, data_out←0, data_req deasserts combinationally.
  - The partial block is discarded; no resume.
- Simultaneous tx_start with tx_valid=0: no start.
- en_scram is sampled per bit; software shall change it only while idle.

Test Plan:
- Reset: rst8=1 for 3 edges with tx_start=1, tx_valid=1 → data_out=0, busy=0, data_req=0 throughout.
- OS block, en_scram=0, k=1, bytes 8'hA5 ×16:
  - data_out = 1,0 then 1,0,1,0,0,1,0,1 repeated 16 times.
  - busy low after 130 bits.
  - Exactly 16 data_req pulses, at cnt=1,9,…,121.
- Data block, k=0, en_scram=2'b01, bytes 8'h00:
  - Header 0,1.
  - 128 payload bits equal the first 128 LFSR s[22] outputs from seed 23'h1DBFBC, per the reference model.
- Back-to-back: tx_start at cnt==129 with k=0, repeated 68 times, en_scram=2'd3, random bytes:
  - 68×130 contiguous bits with no idle gap.
  - LFSR continuous, matching the model.
- Mid-block abort: tx_valid dropped at cnt=50 → data_out=0 next edge, busy=0. A restart after tx_valid returns begins with the LFSR at SEED.
- tx_start pulse at cnt=60 → ignored; the block completes unchanged.
